cache_line_adapter: RTL



---
 rtl/cache_pkg.sv | 20 ++
 rtl/line_beat_counter.sv | 28 ++
 rtl/cache_line_adapter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and defaults: the line-adapter state type and line geometry,
// plus a helper for line-aligning a byte address.
package cache_pkg;

  localparam int S_OFFSET_DEFAULT = 5;
  localparam int WORDS_PER_LINE   = 2 ** (S_OFFSET_DEFAULT - 2);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WB,
    DONE
  } adapter_state_t;

  // Clears the byte-offset bits, giving the address of the line's first byte.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int s_off);
    return addr & ~((32'd1 << s_off) - 32'd1);
  endfunction

endpackage

// File: rtl/line_beat_counter.sv
// Word-index counter for a line burst: loads a start index, advances on enable,
// wraps modulo 2**width and flags the last index.
module line_beat_counter #(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] start,
  input  logic             en,
  output logic [width-1:0] idx,
  output logic             last
);

  // NOTE: state is written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= start;
    end else if (en) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == '1);

endmodule

// File: rtl/cache_line_adapter.sv
// Splits a cache-line fill/writeback into sequential 32-bit memory beats.
// Optional: CACHE_CRITICAL_WORD_FIRST_EN starts fills at the addressed word and wraps.
module cache_line_adapter
  import cache_pkg::*;
#(
  parameter  int s_offset = S_OFFSET_DEFAULT,
  localparam int s_line   = 8 * (2 ** s_offset),
  localparam int n_words  = 2 ** (s_offset - 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [31:0]       line_addr,
  input  logic [s_line-1:0] line_wdata,
  output logic [s_line-1:0] line_rdata,
  output logic              line_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_resp
);

  localparam int bw = $clog2(n_words);

  adapter_state_t    state, next_state;
  logic [31:0]       base;
  logic [s_line-1:0] wline;
  logic [bw-1:0]     beat;
  logic [bw-1:0]     start_idx;
  logic              load;
  logic              advance;
  logic              done_beat;
  logic              capture;

  assign load    = (state == IDLE);
  assign advance = mem_resp && ((state == FILL) || (state == WB));
  assign capture = (state == IDLE) && (next_state != IDLE);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic [bw-1:0] xfer;
  logic          beat_wrap;

  // Writes win arbitration, so only a pure read begins at the addressed word.
  assign start_idx = line_write ? '0 : line_addr[s_offset-1:2];

  line_beat_counter #(.width(bw)) u_beat (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .start (start_idx),
    .en    (advance),
    .idx   (beat),
    .last  (beat_wrap)
  );

  line_beat_counter #(.width(bw)) u_xfer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .start ('0),
    .en    (advance),
    .idx   (xfer),
    .last  (done_beat)
  );
`else
  assign start_idx = '0;

  line_beat_counter #(.width(bw)) u_beat (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .start (start_idx),
    .en    (advance),
    .idx   (beat),
    .last  (done_beat)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (line_write) begin
          next_state = WB;
        end else if (line_read) begin
          next_state = FILL;
        end
      end
      FILL, WB: begin
        if (mem_resp && done_beat) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    line_resp = 1'b0;
    unique case (state)
      FILL, WB: begin
        mem_read  = (state == FILL);
        mem_write = (state == WB);
        mem_addr  = base + 32'({beat, 2'b00});
        mem_wdata = wline[32*beat +: 32];
      end
      DONE:    line_resp = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the wide line registers are reset on purpose: an aborted fill must not leak partial data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base  <= '0;
      wline <= '0;
    end else if (capture) begin
      base  <= line_base(line_addr, s_offset);
      wline <= line_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_rdata <= '0;
    end else if ((state == FILL) && mem_resp) begin
      line_rdata[32*beat +: 32] <= mem_rdata;
    end
  end

endmodule
